// File: rtl/modexp_if.sv
// Handshake and operand bundle for modexp_engine.
//   start  : request, sampled only while the engine is idle
//   mode   : 0 = a*b mod m, 1 = a^b mod m
//   a, b, m: operands and modulus, captured on the accepted start edge
//   result : final value, held until the next accepted start
//   done   : high while idle with a valid result
//   busy   : high from the cycle after start is accepted until done rises
//   err    : modulus was zero, valid alongside done
interface modexp_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic             mode;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] m;
    logic [WIDTH-1:0] result;
    logic             done;
    logic             busy;
    logic             err;

    modport master (
        output start, mode, a, b, m,
        input  result, done, busy, err
    );

    modport slave (
        input  start, mode, a, b, m,
        output result, done, busy, err
    );
endinterface

// File: rtl/modexp_engine.sv
// Sequential modular arithmetic engine.
//   mode 0: result = a*b mod m (shift-and-add)
//   mode 1: result = a^b mod m (square-and-multiply over a shared mulmod)
// Ports:
//   clk   : clock, rising edge
//   reset : asynchronous, active-low
//   bus   : modexp_if slave (start/mode/a/b/m in, result/done/busy/err out)
//
// state      | meaning
// -----------+-----------------------------------------------------------
// S_IDLE     | waiting for start; result/done/err held
// S_LOAD     | m==0 check; set up reduction a mod m = mulmod(1 mod m, a)
// S_CHK      | exponent loop head; finish, multiply, or skip to shift
// S_REDUCE   | latch a mod m; set up mode-0 product or mode-1 loop
// S_MUL_INIT | set up mulmod(res, base) or mulmod(base, base)
// S_MUL_STEP | one multiplier bit per cycle, returns to r_ret
// S_PEXP_BIT | absorb multiply result, shift exponent, maybe square
// S_PEXP_SQR | absorb squared base
// S_FINISH   | write result, raise done, drop busy
module modexp_engine #(
    parameter int WIDTH = 32
) (
    input  logic    clk,
    input  logic    reset,
    modexp_if.slave bus
);
    typedef enum logic [3:0] {
        S_IDLE, S_LOAD, S_CHK, S_REDUCE, S_MUL_INIT,
        S_MUL_STEP, S_PEXP_BIT, S_PEXP_SQR, S_FINISH
    } state_t;

    state_t           r_state, w_state_nxt, r_ret;
    logic             r_mode;
    logic [WIDTH-1:0] r_a, r_b, r_m;
    logic [WIDTH-1:0] r_acc, r_x, r_mplr;
    logic [WIDTH-1:0] r_res, r_base, r_e;
    logic [WIDTH-1:0] r_result;
    logic             r_done, r_busy, r_err;

    logic [WIDTH-1:0] w_one;
    logic [WIDTH:0]   w_m_ext, w_sum, w_dbl;
    logic [WIDTH-1:0] w_sum_red, w_dbl_red;
    logic [WIDTH-1:0] w_acc_step, w_x_step;
    logic             w_mul_last;

    assign w_one = (r_m == WIDTH'(1)) ? {WIDTH{1'b0}} : WIDTH'(1);

    // Sums are one bit wider than the operands so acc+x and 2x never wrap
    // before the compare. The subtracted value is known to be < m, so the
    // low WIDTH bits of the difference are exact.
    assign w_m_ext   = {1'b0, r_m};
    assign w_sum     = {1'b0, r_acc} + {1'b0, r_x};
    assign w_dbl     = {r_x, 1'b0};
    assign w_sum_red = w_sum[WIDTH-1:0] - r_m;
    assign w_dbl_red = w_dbl[WIDTH-1:0] - r_m;

    assign w_acc_step = !r_mplr[0]          ? r_acc :
                        (w_sum >= w_m_ext)  ? w_sum_red : w_sum[WIDTH-1:0];
    assign w_x_step   = (w_dbl >= w_m_ext)  ? w_dbl_red : w_dbl[WIDTH-1:0];

    // Last step when no set bits remain above bit 0; a zero multiplier
    // therefore costs a single no-op cycle.
    assign w_mul_last = (r_mplr[WIDTH-1:1] == '0);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:     if (bus.start) w_state_nxt = S_LOAD;
            S_LOAD:     w_state_nxt = (r_m == '0) ? S_FINISH : S_MUL_STEP;
            S_MUL_STEP: if (w_mul_last) w_state_nxt = r_ret;
            S_REDUCE:   w_state_nxt = r_mode ? S_CHK : S_MUL_STEP;
            S_CHK: begin
                if (r_e == '0)  w_state_nxt = S_FINISH;
                else if (r_e[0]) w_state_nxt = S_MUL_INIT;
                else             w_state_nxt = S_PEXP_BIT;
            end
            S_MUL_INIT: w_state_nxt = S_MUL_STEP;
            S_PEXP_BIT: w_state_nxt = (r_e[WIDTH-1:1] != '0) ? S_MUL_INIT : S_FINISH;
            S_PEXP_SQR: w_state_nxt = S_CHK;
            S_FINISH:   w_state_nxt = S_IDLE;
            default:    w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_ret    <= S_IDLE;
            r_mode   <= 1'b0;
            r_a      <= '0;
            r_b      <= '0;
            r_m      <= '0;
            r_acc    <= '0;
            r_x      <= '0;
            r_mplr   <= '0;
            r_res    <= '0;
            r_base   <= '0;
            r_e      <= '0;
            r_result <= '0;
            r_done   <= 1'b0;
            r_busy   <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: if (bus.start) begin
                    r_mode <= bus.mode;
                    r_a    <= bus.a;
                    r_b    <= bus.b;
                    r_m    <= bus.m;
                    r_done <= 1'b0;
                    r_err  <= 1'b0;
                    r_busy <= 1'b1;
                end
                S_LOAD: begin
                    if (r_m == '0) r_err <= 1'b1;
                    r_acc  <= '0;
                    r_x    <= w_one;
                    r_mplr <= r_a;
                    r_ret  <= S_REDUCE;
                end
                S_MUL_STEP: begin
                    r_acc  <= w_acc_step;
                    r_x    <= w_x_step;
                    r_mplr <= r_mplr >> 1;
                end
                S_REDUCE: begin
                    // Both setups are loaded; the unused one is harmless.
                    r_base <= r_acc;
                    r_res  <= w_one;
                    r_e    <= r_b;
                    r_acc  <= '0;
                    r_x    <= r_acc;
                    r_mplr <= r_b;
                    r_ret  <= S_FINISH;
                end
                S_CHK: r_ret <= S_PEXP_BIT;
                S_MUL_INIT: begin
                    r_acc  <= '0;
                    r_x    <= r_base;
                    r_mplr <= (r_ret == S_PEXP_BIT) ? r_res : r_base;
                end
                S_PEXP_BIT: begin
                    // e[0] set means we arrived here from the multiply.
                    if (r_e[0]) r_res <= r_acc;
                    r_e   <= r_e >> 1;
                    r_ret <= S_PEXP_SQR;
                end
                S_PEXP_SQR: r_base <= r_acc;
                S_FINISH: begin
                    r_result <= r_err ? {WIDTH{1'b0}} : (r_mode ? r_res : r_acc);
                    r_done   <= 1'b1;
                    r_busy   <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign bus.result = r_result;
    assign bus.done   = r_done;
    assign bus.busy   = r_busy;
    assign bus.err    = r_err;
endmodule

// File: tb/tb_modexp_engine.sv
module tb_modexp_engine;
    localparam int LAT0_32 = 2*32 + 4;
    localparam int LAT1_32 = (2*32 + 2)*(32 + 2) + 8;
    localparam int LAT0_8  = 2*8 + 4;
    localparam int LAT1_8  = (2*8 + 2)*(8 + 2) + 8;

    logic clk;
    logic reset;
    int   n_tests = 0;
    int   n_fail  = 0;

    modexp_if #(.WIDTH(32)) b32();
    modexp_if #(.WIDTH(8))  b8();

    modexp_engine #(.WIDTH(32)) u_dut32 (.clk(clk), .reset(reset), .bus(b32));
    modexp_engine #(.WIDTH(8))  u_dut8  (.clk(clk), .reset(reset), .bus(b8));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic longint unsigned mul_ref(input longint unsigned x, input longint unsigned y,
                                                input longint unsigned mm);
        if (mm == 0) return 0;
        return ((x % mm) * (y % mm)) % mm;
    endfunction

    function automatic longint unsigned pow_ref(input longint unsigned x, input longint unsigned y,
                                                input longint unsigned mm);
        longint unsigned r, bb, e;
        if (mm == 0) return 0;
        r  = 1 % mm;
        bb = x % mm;
        e  = y;
        while (e != 0) begin
            if (e[0]) r = (r * bb) % mm;
            bb = (bb * bb) % mm;
            e  = e >> 1;
        end
        return r;
    endfunction

    task automatic launch32(input logic md, input logic [31:0] ia, ib, im);
        @(negedge clk);
        b32.start = 1'b1; b32.mode = md; b32.a = ia; b32.b = ib; b32.m = im;
        @(posedge clk);
        #1;
        b32.start = 1'b0; b32.mode = ~md; b32.a = ~ia; b32.b = ~ib; b32.m = ~im;
    endtask

    task automatic wait32(input int budget, output int cyc);
        cyc = 0;
        while (b32.done !== 1'b1 && cyc < budget) begin
            @(posedge clk);
            #1;
            cyc++;
        end
    endtask

    task automatic run32(input string tag, input logic md, input logic [31:0] ia, ib, im,
                         input logic [31:0] exp_res, input logic exp_err, output int cyc);
        int bound;
        bound = md ? LAT1_32 : LAT0_32;
        launch32(md, ia, ib, im);
        chk({tag, ".busy_on"}, b32.busy, 1);
        chk({tag, ".done_clr"}, b32.done, 0);
        wait32(bound + 1, cyc);
        chk({tag, ".done"}, b32.done, 1);
        chk({tag, ".busy_off"}, b32.busy, 0);
        chk({tag, ".result"}, b32.result, exp_res);
        chk({tag, ".err"}, b32.err, exp_err);
        chk({tag, ".latency_ok"}, cyc <= bound, 1);
    endtask

    task automatic run8(input string tag, input logic md, input logic [7:0] ia, ib, im,
                        input logic [7:0] exp_res);
        int cyc, bound;
        bound = md ? LAT1_8 : LAT0_8;
        @(negedge clk);
        b8.start = 1'b1; b8.mode = md; b8.a = ia; b8.b = ib; b8.m = im;
        @(posedge clk);
        #1;
        b8.start = 1'b0; b8.a = ~ia; b8.b = ~ib; b8.m = ~im;
        cyc = 0;
        while (b8.done !== 1'b1 && cyc < bound + 1) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        chk({tag, ".done"}, b8.done, 1);
        chk({tag, ".result"}, b8.result, exp_res);
        chk({tag, ".err"}, b8.err, im == 0);
        chk({tag, ".latency_ok"}, cyc <= bound, 1);
    endtask

    initial begin
        int cyc;
        logic md;
        logic [7:0] ra, rb, rm, rexp;

        reset = 1'b0;
        b32.start = 0; b32.mode = 0; b32.a = 0; b32.b = 0; b32.m = 0;
        b8.start  = 0; b8.mode  = 0; b8.a  = 0; b8.b  = 0; b8.m  = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst.result", b32.result, 0);
        chk("rst.done", b32.done, 0);
        chk("rst.busy", b32.busy, 0);
        chk("rst.err", b32.err, 0);
        @(negedge clk);
        reset = 1'b1;

        // mode 0 basics
        run32("mul_7_9_10", 1'b0, 32'd7, 32'd9, 32'd10, 32'd3, 1'b0, cyc);
        repeat (5) @(posedge clk);
        #1;
        chk("mul_hold.result", b32.result, 3);
        chk("mul_hold.done", b32.done, 1);
        run32("mul_wide", 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFB, 32'd16, 1'b0, cyc);
        run32("mul_a0", 1'b0, 32'd0, 32'd12345, 32'd97, 32'd0, 1'b0, cyc);

        // mode 1
        run32("pow_2_10", 1'b1, 32'd2, 32'd10, 32'd1000, 32'd24, 1'b0, cyc);
        run32("pow_3_200", 1'b1, 32'd3, 32'd200, 32'd1000, 32'd1, 1'b0, cyc);
        run32("pow_0_0", 1'b1, 32'd0, 32'd0, 32'd7, 32'd1, 1'b0, cyc);
        run32("pow_m1", 1'b1, 32'd5, 32'd3, 32'd1, 32'd0, 1'b0, cyc);

        // m == 0 in both modes, then a valid start clears err
        run32("mul_m0", 1'b0, 32'd7, 32'd9, 32'd0, 32'd0, 1'b1, cyc);
        chk("mul_m0.cycles", cyc, 2);
        run32("pow_m0", 1'b1, 32'd3, 32'd5, 32'd0, 32'd0, 1'b1, cyc);
        chk("pow_m0.cycles", cyc, 2);
        launch32(1'b0, 32'd7, 32'd9, 32'd10);
        chk("err_clr.err", b32.err, 0);
        chk("err_clr.done", b32.done, 0);
        wait32(LAT0_32 + 1, cyc);
        chk("err_clr.result", b32.result, 3);
        chk("err_clr.err_end", b32.err, 0);

        // start while busy is ignored
        launch32(1'b1, 32'd3, 32'd200, 32'd1000);
        repeat (10) @(posedge clk);
        @(negedge clk);
        b32.start = 1'b1; b32.mode = 1'b0; b32.a = 32'd7; b32.b = 32'd9; b32.m = 32'd10;
        @(posedge clk);
        #1;
        b32.start = 1'b0;
        chk("ign.busy", b32.busy, 1);
        wait32(LAT1_32 + 1, cyc);
        chk("ign.done", b32.done, 1);
        chk("ign.result", b32.result, 1);
        repeat (3) @(posedge clk);
        #1;
        chk("ign.no_restart", b32.busy, 0);

        // reset mid-operation
        launch32(1'b1, 32'd3, 32'd200, 32'd1000);
        repeat (20) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("midrst.result", b32.result, 0);
        chk("midrst.done", b32.done, 0);
        chk("midrst.busy", b32.busy, 0);
        chk("midrst.err", b32.err, 0);
        @(negedge clk);
        reset = 1'b1;
        run32("after_rst", 1'b1, 32'd3, 32'd200, 32'd1000, 32'd1, 1'b0, cyc);

        // WIDTH=8 instance: 200^255 mod 251 = 200^5 mod 251 = 102 (Fermat)
        run8("w8_pow", 1'b1, 8'd200, 8'd255, 8'd251, 8'd102);
        chk("w8_model", pow_ref(200, 255, 251), 102);
        run8("w8_mul", 1'b0, 8'd255, 8'd255, 8'd254, 8'd1);

        for (int i = 0; i < 1000; i++) begin
            md = ($urandom_range(0, 3) == 0);
            ra = 8'($urandom_range(0, 255));
            rb = 8'($urandom_range(0, 255));
            rm = 8'($urandom_range(0, 255));
            rexp = md ? 8'(pow_ref(ra, rb, rm)) : 8'(mul_ref(ra, rb, rm));
            run8($sformatf("rnd%0d_m%0d_%0d_%0d_%0d", i, md, ra, rb, rm), md, ra, rb, rm, rexp);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
